mc_ctrl: RTL and testbench
==========================

Name: mc_ctrl

Overview:
Multi-cycle control unit for the next-generation RISC-V core. It replaces single-cycle decode with a state machine that sequences fetch, decode, execute, memory and writeback, and handshakes with instruction and data memories. The instruction set grows to include JALR, AUIPC and the full branch set. The block sits between the IR/PC registers and the datapath, drives the same EXTOp/ALUOp/NPCOp/WDSel encodings the datapath already decodes, and adds fault trapping, a memory timeout and a retired-instruction counter.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for imem_ready/dmem_ready before trapping; legal range 1..255.
CNT_W, 32, width of retired-instruction counter instret_o.

Ports:
clk  in  1  system clock, rising edge
rstn... no: rst  in  1  asynchronous active-high reset
Op  in  7  opcode from IR
Funct7  in  7  IR[31:25]
Funct3  in  3  IR[14:12]
Zero  in  1  ALU branch-condition flag (1 = condition true for current ALUOp)
imem_ready  in  1  instruction memory data valid
dmem_ready  in  1  data memory access complete
IRWrite  out  1  load IR
PCWrite  out  1  load PC with NPC
RegWrite  out  1  register file write
MemRead  out  1  data memory read request
MemWrite  out  1  data memory write request
imem_req  out  1  instruction fetch request
EXTOp  out  6  immediate-extend select, one-hot
ALUOp  out  5  ALU operation
NPCOp  out  3  next-PC select
ALUSrc  out  1  ALU B from immediate
ALUSrcA  out  1  ALU A from PC (AUIPC)
WDSel  out  2  writeback select
state_o  out  3  current state (debug)
fault_o  out  1  core trapped
cause_o  out  2  00 none, 01 illegal instruction, 10 memory timeout
instret_o  out  CNT_W  retired-instruction count

Behaviour:
- Reset (async, rst=1): state=FETCH. All strobes, fault_o and instret_o are 0. cause_o=00. Timeout counter=0. The state is forced immediately, mid-instruction included, so no partial write follows.
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5. Codes 6 and 7 go to TRAP with cause 01.
- FETCH:
  - imem_req=1.
  - When imem_ready=1, IRWrite=1 for that cycle and the next state is DECODE.
  - Otherwise stay in FETCH and increment the timeout counter.
- DECODE:
  - Classify the instruction. Recognised: R-ALU (add, sub, and, or, xor, sll, srl, sra, slt, sltu), I-ALU incl. shifts, lw, sw, beq/bne/blt/bge/bltu/bgeu, jal, jalr, lui, auipc.
  - An unrecognised Op/Funct combination goes to TRAP with cause 01.
  - Otherwise go to EXEC.
- EXEC:
  - ALUOp, ALUSrc, ALUSrcA and EXTOp are valid for the instruction.
  - Branch: PCWrite=1; NPCOp=001 if Zero else 000; instret increments; next state FETCH.
  - Load/store: next state MEM.
  - All others: next state WB.
- MEM:
  - MemRead (lw) or MemWrite (sw) is held until dmem_ready=1.
  - sw: on dmem_ready, PCWrite=1, NPCOp=000, retire, next state FETCH.
  - lw: on dmem_ready, next state WB.
- WB:
  - RegWrite=1 for one cycle and PCWrite=1 in the same cycle; retire; next state FETCH.
  - WDSel: 01 for lw, 10 for jal/jalr, 00 otherwise.
  - NPCOp: 010 for jal, 100 for jalr, 000 otherwise.
- Control outputs are decoded from the current state and the IR fields. Every strobe is 0 outside its state.
- Timeout:
  - The counter clears on every state change.
  - When it reaches MEM_TIMEOUT while waiting in FETCH or MEM, go to TRAP with cause 10.
  - A ready that arrives in the same cycle as the limit wins.
- TRAP: absorbing. fault_o=1 and all strobes are 0. Only reset exits.
- instret_o increments by 1 each cycle PCWrite=1 and wraps modulo 2^CNT_W.
- Latency with ready asserted immediately:
  - branch: 3 cycles
  - ALU/lui/auipc/jal/jalr/sw: 4 cycles
  - lw: 5 cycles

Decomposition:
- Package mc_ctrl_pkg holds:
  - state encodings and cause codes
  - ALUOp/EXTOp/NPCOp/WDSel constants, identical to the existing shared encode definitions
- Sub-module mc_decode (combinational) produces the instruction class, ALUOp, EXTOp and the illegal flag.
- The FSM, timeout counter and instret counter stay in mc_ctrl.

Test Plan:
1. add (Op=0110011, F7=0, F3=0), both readies tied 1 -> state 0,1,2,4,0; RegWrite=1 only in cycle 4 with ALUOp=00011, WDSel=00, PCWrite=1, NPCOp=000; instret_o 0->1.
2. lw (Op=0000011, F3=010), dmem_ready low 3 cycles then high -> MEM held 4 cycles with MemRead=1; next cycle WB with WDSel=01 and RegWrite=1.
3. beq, Zero=1 in EXEC -> PCWrite=1 and NPCOp=001 in EXEC, RegWrite never 1. Same with Zero=0 -> NPCOp=000.
4. MEM_TIMEOUT=8, sw with dmem_ready stuck 0 -> TRAP after 8 MEM cycles; fault_o=1, cause_o=10, MemWrite=0 from then on; instret unchanged.
5. Op=1111111 -> TRAP directly from DECODE with cause_o=01, no Reg/Mem/PC write; rst pulse returns to FETCH with fault_o=0.
6. CNT_W=4, 17 jal instructions -> instret_o wraps to 1, NPCOp=010 and WDSel=10 in each WB. Assert rst mid-MEM -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, trap causes,
// instruction classes and the datapath control codes (EXTOp/ALUOp/NPCOp/WDSel).
package mc_ctrl_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_e;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [5:0] EXT_ITYPE_SHAMT = 6'b100000;
  localparam logic [5:0] EXT_ITYPE       = 6'b010000;
  localparam logic [5:0] EXT_STYPE       = 6'b001000;
  localparam logic [5:0] EXT_BTYPE       = 6'b000100;
  localparam logic [5:0] EXT_UTYPE       = 6'b000010;
  localparam logic [5:0] EXT_JTYPE       = 6'b000001;

  localparam logic [4:0] ALU_NOP   = 5'b00000;
  localparam logic [4:0] ALU_LUI   = 5'b00001;
  localparam logic [4:0] ALU_AUIPC = 5'b00010;
  localparam logic [4:0] ALU_ADD   = 5'b00011;
  localparam logic [4:0] ALU_SUB   = 5'b00100;
  localparam logic [4:0] ALU_BNE   = 5'b00101;
  localparam logic [4:0] ALU_BLT   = 5'b00110;
  localparam logic [4:0] ALU_BGE   = 5'b00111;
  localparam logic [4:0] ALU_BLTU  = 5'b01000;
  localparam logic [4:0] ALU_BGEU  = 5'b01001;
  localparam logic [4:0] ALU_SLT   = 5'b01010;
  localparam logic [4:0] ALU_SLTU  = 5'b01011;
  localparam logic [4:0] ALU_XOR   = 5'b01100;
  localparam logic [4:0] ALU_OR    = 5'b01101;
  localparam logic [4:0] ALU_AND   = 5'b01110;
  localparam logic [4:0] ALU_SLL   = 5'b01111;
  localparam logic [4:0] ALU_SRL   = 5'b10000;
  localparam logic [4:0] ALU_SRA   = 5'b10001;

  localparam logic [2:0] NPC_PLUS4  = 3'b000;
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JUMP   = 3'b010;
  localparam logic [2:0] NPC_JALR   = 3'b100;

  localparam logic [1:0] WD_ALU = 2'b00;
  localparam logic [1:0] WD_MEM = 2'b01;
  localparam logic [1:0] WD_PC  = 2'b10;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational instruction classifier: maps the IR opcode/funct fields to an
// instruction class, ALU/extend controls and an illegal-instruction flag.
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [6:0] op,
  input  logic [6:0] funct7,
  input  logic [2:0] funct3,
  output cls_e       cls,
  output logic [4:0] alu_op,
  output logic [5:0] ext_op,
  output logic       alu_src,
  output logic       alu_src_a,
  output logic       illegal
);

  always_comb begin
    cls       = C_NONE;
    alu_op    = ALU_NOP;
    ext_op    = 6'b000000;
    alu_src   = 1'b0;
    alu_src_a = 1'b0;
    illegal   = 1'b1;
    case (op)
      OP_R: begin
        cls     = C_R;
        illegal = 1'b0;
        case ({funct7, funct3})
          10'b0000000_000: alu_op = ALU_ADD;
          10'b0100000_000: alu_op = ALU_SUB;
          10'b0000000_111: alu_op = ALU_AND;
          10'b0000000_110: alu_op = ALU_OR;
          10'b0000000_100: alu_op = ALU_XOR;
          10'b0000000_001: alu_op = ALU_SLL;
          10'b0000000_101: alu_op = ALU_SRL;
          10'b0100000_101: alu_op = ALU_SRA;
          10'b0000000_010: alu_op = ALU_SLT;
          10'b0000000_011: alu_op = ALU_SLTU;
          default:         illegal = 1'b1;
        endcase
      end
      OP_I: begin
        cls     = C_I;
        alu_src = 1'b1;
        ext_op  = EXT_ITYPE;
        illegal = 1'b0;
        case (funct3)
          3'b000: alu_op = ALU_ADD;
          3'b010: alu_op = ALU_SLT;
          3'b011: alu_op = ALU_SLTU;
          3'b100: alu_op = ALU_XOR;
          3'b110: alu_op = ALU_OR;
          3'b111: alu_op = ALU_AND;
          3'b001: begin
            ext_op = EXT_ITYPE_SHAMT;
            alu_op = ALU_SLL;
            if (funct7 != 7'b0000000) illegal = 1'b1;
          end
          default: begin
            // funct3 101: imm[11:5] picks logical vs arithmetic right shift
            ext_op = EXT_ITYPE_SHAMT;
            if (funct7 == 7'b0000000)      alu_op = ALU_SRL;
            else if (funct7 == 7'b0100000) alu_op = ALU_SRA;
            else                           illegal = 1'b1;
          end
        endcase
      end
      OP_LOAD: begin
        cls     = C_LOAD;
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        ext_op  = EXT_ITYPE;
        illegal = (funct3 != 3'b010);
      end
      OP_STORE: begin
        cls     = C_STORE;
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        ext_op  = EXT_STYPE;
        illegal = (funct3 != 3'b010);
      end
      OP_BRANCH: begin
        cls     = C_BRANCH;
        ext_op  = EXT_BTYPE;
        illegal = 1'b0;
        case (funct3)
          3'b000:  alu_op = ALU_SUB;
          3'b001:  alu_op = ALU_BNE;
          3'b100:  alu_op = ALU_BLT;
          3'b101:  alu_op = ALU_BGE;
          3'b110:  alu_op = ALU_BLTU;
          3'b111:  alu_op = ALU_BGEU;
          default: illegal = 1'b1;
        endcase
      end
      OP_JAL: begin
        cls     = C_JAL;
        ext_op  = EXT_JTYPE;
        illegal = 1'b0;
      end
      OP_JALR: begin
        cls     = C_JALR;
        alu_op  = ALU_ADD;
        alu_src = 1'b1;
        ext_op  = EXT_ITYPE;
        illegal = (funct3 != 3'b000);
      end
      OP_LUI: begin
        cls     = C_LUI;
        alu_op  = ALU_LUI;
        alu_src = 1'b1;
        ext_op  = EXT_UTYPE;
        illegal = 1'b0;
      end
      OP_AUIPC: begin
        cls       = C_AUIPC;
        alu_op    = ALU_AUIPC;
        alu_src   = 1'b1;
        alu_src_a = 1'b1;
        ext_op    = EXT_UTYPE;
        illegal   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/exec/mem/writeback,
// traps on illegal instructions or memory timeouts, counts retired instructions.
module mc_ctrl
  import mc_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       Op,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic             Zero,
  input  logic             imem_ready,
  input  logic             dmem_ready,
  output logic             IRWrite,
  output logic             PCWrite,
  output logic             RegWrite,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             imem_req,
  output logic [5:0]       EXTOp,
  output logic [4:0]       ALUOp,
  output logic [2:0]       NPCOp,
  output logic             ALUSrc,
  output logic             ALUSrcA,
  output logic [1:0]       WDSel,
  output logic [2:0]       state_o,
  output logic             fault_o,
  output logic [1:0]       cause_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] instret_q, instret_d;

  cls_e       dec_cls;
  logic [4:0] dec_alu_op;
  logic [5:0] dec_ext_op;
  logic       dec_alu_src;
  logic       dec_alu_src_a;
  logic       dec_illegal;

  mc_decode u_decode (
    .op        (Op),
    .funct7    (Funct7),
    .funct3    (Funct3),
    .cls       (dec_cls),
    .alu_op    (dec_alu_op),
    .ext_op    (dec_ext_op),
    .alu_src   (dec_alu_src),
    .alu_src_a (dec_alu_src_a),
    .illegal   (dec_illegal)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cause_q   <= CAUSE_NONE;
      cnt_q     <= 8'd0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      cnt_q     <= cnt_d;
      instret_q <= instret_d;
    end
  end

  // A ready seen on the limit cycle is checked first, so it beats the timeout.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          state_d = S_DECODE;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (dec_illegal) begin
          state_d = S_TRAP;
          cause_d = CAUSE_ILLEGAL;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (dec_cls == C_BRANCH)                           state_d = S_FETCH;
        else if (dec_cls == C_LOAD || dec_cls == C_STORE)  state_d = S_MEM;
        else                                               state_d = S_WB;
      end
      S_MEM: begin
        if (dmem_ready) begin
          state_d = (dec_cls == C_STORE) ? S_FETCH : S_WB;
        end else if (cnt_q == TO_LAST) begin
          state_d = S_TRAP;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      S_WB:    state_d = S_FETCH;
      S_TRAP:  state_d = S_TRAP;
      default: begin
        state_d = S_TRAP;
        cause_d = CAUSE_ILLEGAL;
      end
    endcase
  end

  always_comb begin
    if (state_d != state_q)
      cnt_d = 8'd0;
    else if (state_q == S_FETCH || state_q == S_MEM)
      cnt_d = cnt_q + 8'd1;
    else
      cnt_d = 8'd0;
    instret_d = instret_q + {{(CNT_W-1){1'b0}}, PCWrite};
  end

  // Everything is held at 0 while rst is high so a reset mid-instruction
  // cannot let a write strobe leak through before the state register settles.
  always_comb begin
    IRWrite  = 1'b0;
    PCWrite  = 1'b0;
    RegWrite = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    imem_req = 1'b0;
    EXTOp    = 6'b000000;
    ALUOp    = ALU_NOP;
    NPCOp    = NPC_PLUS4;
    ALUSrc   = 1'b0;
    ALUSrcA  = 1'b0;
    WDSel    = WD_ALU;
    if (!rst) begin
      if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
        EXTOp   = dec_ext_op;
        ALUOp   = dec_alu_op;
        ALUSrc  = dec_alu_src;
        ALUSrcA = dec_alu_src_a;
      end
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          IRWrite  = imem_ready;
        end
        S_EXEC: begin
          if (dec_cls == C_BRANCH) begin
            PCWrite = 1'b1;
            NPCOp   = Zero ? NPC_BRANCH : NPC_PLUS4;
          end
        end
        S_MEM: begin
          MemRead  = (dec_cls == C_LOAD);
          MemWrite = (dec_cls == C_STORE);
          PCWrite  = (dec_cls == C_STORE) && dmem_ready;
        end
        S_WB: begin
          RegWrite = 1'b1;
          PCWrite  = 1'b1;
          if (dec_cls == C_LOAD)                             WDSel = WD_MEM;
          else if (dec_cls == C_JAL || dec_cls == C_JALR)    WDSel = WD_PC;
          if (dec_cls == C_JAL)                              NPCOp = NPC_JUMP;
          else if (dec_cls == C_JALR)                        NPCOp = NPC_JALR;
        end
        default: ;
      endcase
    end
  end

  assign state_o   = state_q;
  assign fault_o   = (state_q == S_TRAP) && !rst;
  assign cause_o   = cause_q;
  assign instret_o = instret_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: per-cycle expected output vectors are queued
// alongside stimulus rows and compared against the DUT as each cycle runs.
module tb_mc_ctrl;
  localparam int TO = 8;
  localparam int CW = 4;
  localparam int W  = 34;

  localparam logic [4:0] A_NOP = 5'b00000, A_LUI = 5'b00001, A_AUIPC = 5'b00010;
  localparam logic [4:0] A_ADD = 5'b00011, A_SUB = 5'b00100, A_BLTU = 5'b01000;
  localparam logic [4:0] A_BGE = 5'b00111, A_SLL = 5'b01111, A_SRA = 5'b10001;
  localparam logic [5:0] E_NO = 6'b000000, E_SH = 6'b100000, E_I = 6'b010000;
  localparam logic [5:0] E_S = 6'b001000, E_B = 6'b000100, E_U = 6'b000010, E_J = 6'b000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [6:0] op = 7'd0, f7 = 7'd0;
  logic [2:0] f3 = 3'd0;
  logic zero = 1'b0, iready = 1'b0, dready = 1'b0;

  logic IRWrite, PCWrite, RegWrite, MemRead, MemWrite, imem_req, ALUSrc, ALUSrcA;
  logic [5:0] EXTOp;
  logic [4:0] ALUOp;
  logic [2:0] NPCOp, state_o;
  logic [1:0] WDSel, cause_o;
  logic fault_o;
  logic [CW-1:0] instret_o;

  mc_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .Op(op), .Funct7(f7), .Funct3(f3), .Zero(zero),
    .imem_ready(iready), .dmem_ready(dready),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemRead(MemRead),
    .MemWrite(MemWrite), .imem_req(imem_req), .EXTOp(EXTOp), .ALUOp(ALUOp),
    .NPCOp(NPCOp), .ALUSrc(ALUSrc), .ALUSrcA(ALUSrcA), .WDSel(WDSel),
    .state_o(state_o), .fault_o(fault_o), .cause_o(cause_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  logic [W-1:0]  exp_q[$];
  logic [19:0]   stim_q[$];
  int            n_vec = 0;
  int            n_err = 0;
  logic [CW-1:0] er = '0;
  logic [W-1:0]  got, want;

  wire [W-1:0] obs = {state_o, IRWrite, PCWrite, RegWrite, MemRead, MemWrite, imem_req,
                      NPCOp, WDSel, ALUOp, EXTOp, ALUSrc, ALUSrcA, fault_o, cause_o, instret_o};

  // strb = {IRWrite, PCWrite, RegWrite, MemRead, MemWrite, imem_req}; src = {ALUSrc, ALUSrcA}
  function automatic logic [W-1:0] ev(input logic [2:0] st, input logic [5:0] strb,
                                      input logic [2:0] npc, input logic [1:0] wd,
                                      input logic [4:0] alu, input logic [5:0] ext,
                                      input logic [1:0] src, input logic [2:0] fc);
    return {st, strb, npc, wd, alu, ext, src, fc, er};
  endfunction

  task automatic push_row(input logic [19:0] stim, input logic [W-1:0] e);
    stim_q.push_back(stim);
    exp_q.push_back(e);
    if (e[W-5]) er = er + 1'b1;
  endtask

  task automatic push_simple(input logic [6:0] o, input logic [6:0] g7, input logic [2:0] g3,
                             input logic [4:0] alu, input logic [5:0] ext, input logic [1:0] src,
                             input logic [2:0] npc, input logic [1:0] wd);
    push_row({o, g7, g3, 3'b110}, ev(3'd0, 6'b100001, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({o, g7, g3, 3'b110}, ev(3'd1, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({o, g7, g3, 3'b110}, ev(3'd2, 6'b000000, 3'd0, 2'd0, alu, ext, src, 3'b000));
    push_row({o, g7, g3, 3'b110}, ev(3'd4, 6'b011000, npc, wd, alu, ext, src, 3'b000));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    er = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    exp_q.push_back({W{1'b0}});
    #1;
    got = obs;
    want = exp_q.pop_front();
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL reset_outputs: got %h expected %h", got, want);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_alu();
    int i = 0;
    push_simple(7'b0110011, 7'b0000000, 3'b000, A_ADD, E_NO, 2'b00, 3'b000, 2'b00);
    push_simple(7'b0110011, 7'b0100000, 3'b000, A_SUB, E_NO, 2'b00, 3'b000, 2'b00);
    push_simple(7'b0110011, 7'b0100000, 3'b101, A_SRA, E_NO, 2'b00, 3'b000, 2'b00);
    push_simple(7'b0010011, 7'b1010101, 3'b000, A_ADD, E_I,  2'b10, 3'b000, 2'b00);
    push_simple(7'b0010011, 7'b0000000, 3'b001, A_SLL, E_SH, 2'b10, 3'b000, 2'b00);
    push_simple(7'b0110111, 7'b0011001, 3'b110, A_LUI, E_U,  2'b10, 3'b000, 2'b00);
    push_simple(7'b0010111, 7'b0000000, 3'b011, A_AUIPC, E_U, 2'b11, 3'b000, 2'b00);
    push_simple(7'b1100111, 7'b0000000, 3'b000, A_ADD, E_I,  2'b10, 3'b100, 2'b10);
    while (stim_q.size() > 0) begin
      {op, f7, f3, iready, dready, zero} = stim_q.pop_front();
      #1;
      got = obs;
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL alu cyc %0d: got %h expected %h", i, got, want);
      end
      i++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_load_store();
    int i = 0;
    logic [19:0] lw = {7'b0000011, 7'b0000000, 3'b010, 3'b000};
    logic [19:0] sw = {7'b0100011, 7'b0000000, 3'b010, 3'b000};
    push_row(lw | 20'd4, ev(3'd0, 6'b100001, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row(lw, ev(3'd1, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row(lw, ev(3'd2, 6'b000000, 3'd0, 2'd0, A_ADD, E_I, 2'b10, 3'b000));
    for (int k = 0; k < 3; k++)
      push_row(lw, ev(3'd3, 6'b000100, 3'd0, 2'd0, A_ADD, E_I, 2'b10, 3'b000));
    push_row(lw | 20'd2, ev(3'd3, 6'b000100, 3'd0, 2'd0, A_ADD, E_I, 2'b10, 3'b000));
    push_row(lw, ev(3'd4, 6'b011000, 3'd0, 2'b01, A_ADD, E_I, 2'b10, 3'b000));
    push_row(sw | 20'd6, ev(3'd0, 6'b100001, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row(sw | 20'd6, ev(3'd1, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row(sw | 20'd6, ev(3'd2, 6'b000000, 3'd0, 2'd0, A_ADD, E_S, 2'b10, 3'b000));
    push_row(sw | 20'd6, ev(3'd3, 6'b010010, 3'd0, 2'd0, A_ADD, E_S, 2'b10, 3'b000));
    while (stim_q.size() > 0) begin
      {op, f7, f3, iready, dready, zero} = stim_q.pop_front();
      #1;
      got = obs;
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL load_store cyc %0d: got %h expected %h", i, got, want);
      end
      i++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_branch();
    int i = 0;
    logic [16:0] beq  = {7'b1100011, 7'b0000000, 3'b000};
    logic [16:0] bltu = {7'b1100011, 7'b0000000, 3'b110};
    logic [16:0] bge  = {7'b1100011, 7'b0000000, 3'b101};
    for (int z = 1; z >= 0; z--) begin
      push_row({beq, 2'b11, 1'(z)}, ev(3'd0, 6'b100001, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
      push_row({beq, 2'b11, 1'(z)}, ev(3'd1, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
      push_row({beq, 2'b11, 1'(z)}, ev(3'd2, 6'b010000, {2'b00, 1'(z)}, 2'd0, A_SUB, E_B, 2'b00, 3'b000));
    end
    push_row({bltu, 3'b111}, ev(3'd0, 6'b100001, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({bltu, 3'b111}, ev(3'd1, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({bltu, 3'b111}, ev(3'd2, 6'b010000, 3'b001, 2'd0, A_BLTU, E_B, 2'b00, 3'b000));
    push_row({bge, 3'b110}, ev(3'd0, 6'b100001, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({bge, 3'b110}, ev(3'd1, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({bge, 3'b110}, ev(3'd2, 6'b010000, 3'b000, 2'd0, A_BGE, E_B, 2'b00, 3'b000));
    while (stim_q.size() > 0) begin
      {op, f7, f3, iready, dready, zero} = stim_q.pop_front();
      #1;
      got = obs;
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want || RegWrite !== 1'b0) begin
        n_err++;
        $display("FAIL branch cyc %0d: got %h expected %h", i, got, want);
      end
      i++;
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_timeout();
    int i = 0;
    logic [16:0] sw = {7'b0100011, 7'b0000000, 3'b010};
    // store whose ready lands exactly on the last allowed MEM cycle
    push_row({sw, 3'b100}, ev(3'd0, 6'b100001, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({sw, 3'b100}, ev(3'd1, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({sw, 3'b100}, ev(3'd2, 6'b000000, 3'd0, 2'd0, A_ADD, E_S, 2'b10, 3'b000));
    for (int k = 0; k < TO - 1; k++)
      push_row({sw, 3'b100}, ev(3'd3, 6'b000010, 3'd0, 2'd0, A_ADD, E_S, 2'b10, 3'b000));
    push_row({sw, 3'b110}, ev(3'd3, 6'b010010, 3'd0, 2'd0, A_ADD, E_S, 2'b10, 3'b000));
    // store with dmem_ready stuck low traps after TO MEM cycles
    push_row({sw, 3'b100}, ev(3'd0, 6'b100001, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({sw, 3'b100}, ev(3'd1, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({sw, 3'b100}, ev(3'd2, 6'b000000, 3'd0, 2'd0, A_ADD, E_S, 2'b10, 3'b000));
    for (int k = 0; k < TO; k++)
      push_row({sw, 3'b100}, ev(3'd3, 6'b000010, 3'd0, 2'd0, A_ADD, E_S, 2'b10, 3'b000));
    for (int k = 0; k < 3; k++)
      push_row({sw, 3'b110}, ev(3'd5, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b110));
    while (stim_q.size() > 0) begin
      {op, f7, f3, iready, dready, zero} = stim_q.pop_front();
      #1;
      got = obs;
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL mem_timeout cyc %0d: got %h expected %h", i, got, want);
      end
      i++;
      @(posedge clk);
      @(negedge clk);
    end
    do_reset();
    i = 0;
    for (int k = 0; k < TO; k++)
      push_row({sw, 3'b000}, ev(3'd0, 6'b000001, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    for (int k = 0; k < 2; k++)
      push_row({sw, 3'b100}, ev(3'd5, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b110));
    while (stim_q.size() > 0) begin
      {op, f7, f3, iready, dready, zero} = stim_q.pop_front();
      #1;
      got = obs;
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL fetch_timeout cyc %0d: got %h expected %h", i, got, want);
      end
      i++;
      @(posedge clk);
      @(negedge clk);
    end
    do_reset();
  endtask

  task automatic test_illegal();
    int i = 0;
    logic [16:0] bad [3];
    bad[0] = {7'b1111111, 7'b0000000, 3'b000};
    bad[1] = {7'b0110011, 7'b0100000, 3'b001};
    bad[2] = {7'b1100011, 7'b0000000, 3'b010};
    for (int b = 0; b < 3; b++) begin
      i = 0;
      push_row({bad[b], 3'b111}, ev(3'd0, 6'b100001, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
      push_row({bad[b], 3'b111}, ev(3'd1, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
      push_row({bad[b], 3'b111}, ev(3'd5, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b101));
      push_row({bad[b], 3'b111}, ev(3'd5, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b101));
      while (stim_q.size() > 0) begin
        {op, f7, f3, iready, dready, zero} = stim_q.pop_front();
        #1;
        got = obs;
        want = exp_q.pop_front();
        n_vec++;
        if (got !== want) begin
          n_err++;
          $display("FAIL illegal_%0d cyc %0d: got %h expected %h", b, i, got, want);
        end
        i++;
        @(posedge clk);
        @(negedge clk);
      end
      rst = 1'b1;
      #1;
      n_vec++;
      if (fault_o !== 1'b0 || state_o !== 3'd0 || cause_o !== 2'b00) begin
        n_err++;
        $display("FAIL illegal_%0d reset_exit: got state %0d fault %b cause %b expected 0 0 00",
                 b, state_o, fault_o, cause_o);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      er = '0;
    end
  endtask

  task automatic test_jal_wrap_and_reset();
    int i = 0;
    logic [16:0] sw = {7'b0100011, 7'b0000000, 3'b010};
    do_reset();
    for (int k = 0; k < 17; k++)
      push_simple(7'b1101111, 7'($urandom_range(0, 127)), 3'($urandom_range(0, 7)),
                  A_NOP, E_J, 2'b00, 3'b010, 2'b10);
    push_row({sw, 3'b100}, ev(3'd0, 6'b100001, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({sw, 3'b100}, ev(3'd1, 6'b000000, 3'd0, 2'd0, A_NOP, E_NO, 2'b00, 3'b000));
    push_row({sw, 3'b100}, ev(3'd2, 6'b000000, 3'd0, 2'd0, A_ADD, E_S, 2'b10, 3'b000));
    push_row({sw, 3'b100}, ev(3'd3, 6'b000010, 3'd0, 2'd0, A_ADD, E_S, 2'b10, 3'b000));
    while (stim_q.size() > 0) begin
      {op, f7, f3, iready, dready, zero} = stim_q.pop_front();
      #1;
      got = obs;
      want = exp_q.pop_front();
      n_vec++;
      if (got !== want) begin
        n_err++;
        $display("FAIL jal_wrap cyc %0d: got %h expected %h", i, got, want);
      end
      i++;
      @(posedge clk);
      @(negedge clk);
    end
    n_vec++;
    if (instret_o !== 4'd1) begin
      n_err++;
      $display("FAIL instret_wrap: got %0d expected 1", instret_o);
    end
    // still in MEM with MemWrite high: reset must clear everything at once
    rst = 1'b1;
    #1;
    n_vec++;
    if (obs !== {W{1'b0}}) begin
      n_err++;
      $display("FAIL reset_mid_mem: got %h expected %h", obs, {W{1'b0}});
    end
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    er = '0;
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_store();
    test_branch();
    test_timeout();
    test_illegal();
    test_jal_wrap_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
